// File: rtl/skel_pass_sequencer.sv
// Thinning-pass sequencer: scans the image, offers 3x3 windows to an external
// decision block, defers deletions to a per-pass writeback, repeats until stable.
module skel_pass_sequencer #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int MAX_PASSES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_count,
    output logic             ram_we,
    output logic [bitSize:0] ram_primary_address,
    output logic [bitSize:0] ram_dual_read_address,
    output logic [7:0]       ram_data_in,
    input  logic [7:0]       ram_dual_output,
    output logic             win_valid,
    output logic [8:0]       win_pixels,
    output logic             win_subiter,
    input  logic             win_ready,
    input  logic             win_delete
);
    localparam int AW = bitSize + 1;
    localparam int NN = N * N;
    localparam int MW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [AW-1:0] LAST_PIX   = AW'(NN - 1);
    localparam logic [AW-1:0] LAST_COL   = AW'(N - 1);
    localparam logic [7:0]    PASS_LIMIT = 8'(MAX_PASSES);

    typedef enum logic [2:0] {
        IDLE, FETCH, OFFER, NEXT, WB_SCAN, WB_WRITE, PASS_END, FINISH
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] pixel, row, col, idx;
    logic [3:0]    k;
    logic [8:0]    win;
    logic [NN-1:0] mask;
    logic          wb_second, subiter, pass_changed;
    logic [1:0]    zero_cnt, zero_cnt_nxt;
    logic [7:0]    pass_count_nxt;

    int            nr, nc;
    logic          nb_in_image;
    logic [AW-1:0] nb_addr;

    // Neighbour k of the current pixel, row-major over dr,dc in {-1,0,1}.
    always_comb begin
        nr = int'(row) + int'(k) / 3 - 1;
        nc = int'(col) + int'(k) % 3 - 1;
        nb_in_image = (nr >= 0) && (nr < N) && (nc >= 0) && (nc < N);
        nb_addr = AW'(nr * N + nc);
    end

    always_comb begin
        zero_cnt_nxt   = pass_changed ? 2'd0 : zero_cnt + 2'd1;
        pass_count_nxt = pass_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = FETCH;
            FETCH:    if (k == 4'd8) state_nxt = win[4] ? OFFER : NEXT;
            OFFER:    if (win_ready) state_nxt = NEXT;
            NEXT:     state_nxt = (pixel == LAST_PIX) ? WB_SCAN : FETCH;
            WB_SCAN: begin
                if (mask[idx[MW-1:0]])    state_nxt = WB_WRITE;
                else if (idx == LAST_PIX) state_nxt = PASS_END;
            end
            WB_WRITE: if (wb_second) state_nxt = (idx == LAST_PIX) ? PASS_END : WB_SCAN;
            PASS_END: state_nxt = (zero_cnt_nxt == 2'd2 || pass_count_nxt == PASS_LIMIT)
                                  ? FINISH : FETCH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel        <= '0;
            row          <= '0;
            col          <= '0;
            idx          <= '0;
            k            <= '0;
            win          <= '0;
            mask         <= '0;
            wb_second    <= 1'b0;
            subiter      <= 1'b0;
            pass_changed <= 1'b0;
            zero_cnt     <= '0;
            pass_count   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pixel        <= '0;
                    row          <= '0;
                    col          <= '0;
                    k            <= '0;
                    subiter      <= 1'b0;
                    pass_changed <= 1'b0;
                    zero_cnt     <= '0;
                    pass_count   <= '0;
                end
                FETCH: begin
                    win[k] <= nb_in_image && (ram_dual_output != 8'h00);
                    k      <= (k == 4'd8) ? 4'd0 : k + 4'd1;
                end
                OFFER: if (win_ready) mask[pixel[MW-1:0]] <= win_delete;
                NEXT: begin
                    if (pixel == LAST_PIX) begin
                        idx <= '0;
                    end else begin
                        pixel <= pixel + 1'b1;
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                WB_SCAN: begin
                    if (mask[idx[MW-1:0]]) wb_second <= 1'b0;
                    else if (idx != LAST_PIX) idx <= idx + 1'b1;
                end
                // The RAM commits on alternate cycles, so the write is held for two.
                WB_WRITE: begin
                    if (!wb_second) begin
                        wb_second <= 1'b1;
                    end else begin
                        mask[idx[MW-1:0]] <= 1'b0;
                        pass_changed      <= 1'b1;
                        if (idx != LAST_PIX) idx <= idx + 1'b1;
                    end
                end
                PASS_END: begin
                    pass_count   <= pass_count_nxt;
                    subiter      <= ~subiter;
                    zero_cnt     <= zero_cnt_nxt;
                    pass_changed <= 1'b0;
                    pixel        <= '0;
                    row          <= '0;
                    col          <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy                  = (state != IDLE) && (state != FINISH);
    assign done                  = (state == FINISH);
    assign ram_we                = (state == WB_WRITE);
    assign ram_primary_address   = (state == WB_WRITE) ? idx : '0;
    assign ram_dual_read_address = (state == FETCH) ? nb_addr : '0;
    assign ram_data_in           = 8'h00;
    assign win_valid             = (state == OFFER);
    assign win_pixels            = win;
    assign win_subiter           = subiter;
endmodule

// File: tb/tb_skel_pass_sequencer.sv
// Directed bench for skel_pass_sequencer with a behavioural dual-port RAM
// (alternate-cycle commits, junk above the image) and a scripted decision block.
module tb_skel_pass_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, start;
    logic       busy, done, ram_we, win_valid, win_subiter, win_ready, win_delete;
    logic [7:0] pass_count, ram_data_in, ram_dual_output;
    logic [6:0] ram_primary_address, ram_dual_read_address;
    logic [8:0] win_pixels;

    always #5 clk = ~clk;

    skel_pass_sequencer #(.N(8), .bitSize(6), .MAX_PASSES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass_count(pass_count), .ram_we(ram_we),
        .ram_primary_address(ram_primary_address),
        .ram_dual_read_address(ram_dual_read_address),
        .ram_data_in(ram_data_in), .ram_dual_output(ram_dual_output),
        .win_valid(win_valid), .win_pixels(win_pixels), .win_subiter(win_subiter),
        .win_ready(win_ready), .win_delete(win_delete)
    );

    logic [7:0] ram [0:127];
    assign ram_dual_output = ram[ram_dual_read_address];

    int         mode;
    logic       man_ready, man_delete, load_req, sticky, commit_phase;
    int         img_sel;
    int         we_cycles, valid_cycles, offers, we_bad;
    logic [6:0] we_addr_last;
    logic [8:0] win_log [0:31];
    int         tests = 0;
    int         fails = 0;

    always_comb begin
        win_ready  = 1'b1;
        win_delete = 1'b0;
        case (mode)
            1: win_delete = 1'b1;
            2: win_delete = (win_subiter == 1'b0) && (win_pixels == 9'h1FF);
            3: begin
                win_ready  = man_ready;
                win_delete = man_delete;
            end
            default: ;
        endcase
    end

    initial begin
        commit_phase = 1'b0;
        we_cycles = 0; valid_cycles = 0; offers = 0; we_bad = 0; we_addr_last = '0;
        for (int a = 0; a < 128; a++) ram[a] = 8'h00;
        forever begin
            @(negedge clk);
            if (load_req) begin
                for (int a = 0; a < 128; a++) ram[a] = (a >= 64) ? 8'hFF : 8'h00;
                case (img_sel)
                    1: ram[0] = 8'hC3;
                    2: for (int r = 2; r <= 4; r++)
                           for (int c = 2; c <= 4; c++) ram[r*8+c] = 8'h5A;
                    3: ram[9] = 8'h33;
                    default: ;
                endcase
                we_cycles = 0; valid_cycles = 0; offers = 0; we_bad = 0; we_addr_last = '0;
            end else begin
                if (win_valid) valid_cycles++;
                if (win_valid && win_ready) begin
                    if (offers < 32) win_log[offers] = win_pixels;
                    offers++;
                end
                if (ram_we) begin
                    we_cycles++;
                    we_addr_last = ram_primary_address;
                    if (ram_data_in !== 8'h00) we_bad++;
                    if (commit_phase && !sticky) ram[ram_primary_address] = ram_data_in;
                end
            end
            commit_phase = ~commit_phase;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_image(input int sel);
        img_sel  = sel;
        load_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [7:0] exp_pc);
        logic       seen;
        logic [7:0] pc;
        logic       bz;
        seen = 1'b0; pc = '0; bz = 1'b1;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                pc   = pass_count;
                bz   = busy;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_busy_at_done"}, bz, 1'b0);
        check({tag, "_pass_count"}, pc, exp_pc);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, pass_count}, {1'b0, exp_pc});
    endtask

    function automatic int block_mismatch();
        int m = 0;
        logic [7:0] e;
        for (int a = 0; a < 64; a++) begin
            e = ((a / 8) >= 2 && (a / 8) <= 4 && (a % 8) >= 2 && (a % 8) <= 4 && a != 27)
                ? 8'h5A : 8'h00;
            if (ram[a] !== e) m++;
        end
        return m;
    endfunction

    logic [8:0] exp_blk [0:8];
    logic [8:0] w0;
    logic       seen_v;
    int         nz;

    initial begin
        exp_blk = '{9'h1B0, 9'h1F8, 9'h0D8, 9'h1B6, 9'h1FF, 9'h0DB, 9'h036, 9'h03F, 9'h01B};
        rst_n = 1'b0; start = 1'b0; mode = 0; man_ready = 1'b0; man_delete = 1'b0;
        load_req = 1'b0; img_sel = 0; sticky = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", ram_we, 1'b0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_subiter", win_subiter, 1'b0);
        check("rst_pass_count", pass_count, 8'd0);
        check("rst_addrs", {ram_primary_address, ram_dual_read_address}, 14'd0);
        check("rst_data_in", ram_data_in, 8'h00);
        rst_n = 1'b1;

        // All-zero image.
        load_image(0);
        mode = 0;
        pulse_start();
        check("zero_busy_after_start", busy, 1'b1);
        wait_done("zero", 8'd2);
        check("zero_valid_cycles", valid_cycles, 0);
        check("zero_we_cycles", we_cycles, 0);
        nz = 0;
        for (int a = 0; a < 64; a++) if (ram[a] !== 8'h00) nz++;
        check("zero_ram_unchanged", nz, 0);

        // Single corner pixel, deleted on pass 0.
        load_image(1);
        mode = 1;
        pulse_start();
        wait_done("single", 8'd3);
        check("single_offers", offers, 1);
        check("single_window", win_log[0], 9'h010);
        check("single_we_cycles", we_cycles, 2);
        check("single_we_addr", we_addr_last, 7'd0);
        check("single_we_data", we_bad, 0);
        check("single_ram0", ram[0], 8'h00);

        // 3x3 block, only the fully surrounded centre is deleted.
        load_image(2);
        mode = 2;
        pulse_start();
        wait_done("block", 8'd3);
        check("block_offers", offers, 25);
        for (int i = 0; i < 9; i++) check($sformatf("block_win%0d", i), win_log[i], exp_blk[i]);
        check("block_ram27", ram[27], 8'h00);
        check("block_ram_image", block_mismatch(), 0);

        // Stalled decision block; delete asserted only while not ready.
        load_image(3);
        mode = 3; man_ready = 1'b0; man_delete = 1'b1;
        pulse_start();
        seen_v = 1'b0;
        for (int i = 0; i < 2000 && !seen_v; i++) begin
            if (win_valid) seen_v = 1'b1;
            else @(negedge clk);
        end
        check("stall_valid_seen", seen_v, 1'b1);
        w0 = win_pixels;
        check("stall_window", w0, 9'h010);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold%0d", i), {win_valid, win_subiter, win_pixels},
                  {1'b1, 1'b0, w0});
            @(negedge clk);
        end
        man_ready = 1'b1; man_delete = 1'b0;
        @(negedge clk);
        check("stall_valid_drop", win_valid, 1'b0);
        wait_done("stall", 8'd2);
        check("stall_we_cycles", we_cycles, 0);
        check("stall_ram9", ram[9], 8'h33);

        // Pixel that keeps coming back: every pass changes, run hits the pass limit.
        load_image(1);
        mode = 1; sticky = 1'b1;
        pulse_start();
        wait_done("limit", 8'd16);
        check("limit_we_cycles", we_cycles, 32);
        sticky = 1'b0;

        // Reset during writeback, then a clean rerun.
        load_image(1);
        mode = 1;
        pulse_start();
        seen_v = 1'b0;
        for (int i = 0; i < 2000 && !seen_v; i++) begin
            if (ram_we) seen_v = 1'b1;
            else @(negedge clk);
        end
        check("abort_we_seen", seen_v, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_state", {ram_we, busy, win_valid, done}, 4'b0000);
        check("abort_pass_count", pass_count, 8'd0);
        rst_n = 1'b1;
        load_image(1);
        pulse_start();
        wait_done("rerun", 8'd3);
        check("rerun_we_cycles", we_cycles, 2);
        check("rerun_ram0", ram[0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
